// File: rtl/elevator_pkg.sv
// Shared elevator types: controller states, scan direction constants, floor-range helpers.
// No logic of its own; imported by the controller, the request scanner and neighbouring blocks.
// Backpressure: not applicable.
package elevator_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MOVE_UP,
    ST_MOVE_DOWN,
    ST_DOOR_OPEN,
    ST_HALT
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  function automatic logic at_top(input int floor, input int floors);
    return floor == floors - 1;
  endfunction

  function automatic logic at_bottom(input int floor);
    return floor == 0;
  endfunction

  // Direction to keep after serving a floor: reverse only when nothing lies ahead
  // and something (including the opposite hall call here) waits behind.
  function automatic logic door_dir(input logic dir, input logic above, input logic below,
                                    input logic opp_hall, input logic top, input logic bottom);
    logic beyond;
    logic behind;
    beyond = dir ? above : below;
    behind = dir ? below : above;
    if (top)
      return DIR_DOWN;
    if (bottom)
      return DIR_UP;
    if (!beyond && (behind || opp_hall))
      return ~dir;
    return dir;
  endfunction

endpackage

// File: rtl/elevator_req_scan.sv
// Request scan for one floor: any request above/below, hall calls here, stop decisions.
// Purely combinational, zero latency; no backpressure.
module elevator_req_scan
  import elevator_pkg::*;
#(
  parameter int BUTTONS_WIDTH = 8,
  parameter int FLOOR_WIDTH   = 3
) (
  input  logic [FLOOR_WIDTH-1:0]   floor,
  input  logic [BUTTONS_WIDTH-1:0] in_levels,
  input  logic [BUTTONS_WIDTH-1:0] up_levels,
  input  logic [BUTTONS_WIDTH-1:0] down_levels,
  output logic                     up_here,
  output logic                     down_here,
  output logic                     above,
  output logic                     below,
  output logic                     stop_up,
  output logic                     stop_down
);

  logic [BUTTONS_WIDTH-1:0] req;

  assign req       = in_levels | up_levels | down_levels;
  assign up_here   = up_levels[floor];
  assign down_here = down_levels[floor];

  always_comb begin
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < BUTTONS_WIDTH; i++) begin
      if (i > int'(floor)) above = above | req[i];
      if (i < int'(floor)) below = below | req[i];
    end
  end

  // A car heading up only takes a down call here when it is the last thing upward.
  assign stop_up   = in_levels[floor] | up_here | (down_here & ~above);
  assign stop_down = in_levels[floor] | down_here | (up_here & ~below);

endmodule

// File: rtl/elevator_ctrl.sv
// SCAN car motion/door controller: moves floor by floor, opens door, clears served calls.
// Latency: TRAVEL_CYCLES per floor, DOOR_CYCLES dwell; all outputs registered.
// Backpressure: none; emergency_stop halts the car and blocks button entry.
module elevator_ctrl
  import elevator_pkg::*;
#(
  parameter int BUTTONS_WIDTH = 8,
  parameter int FLOOR_WIDTH   = 3,
  parameter int TRAVEL_CYCLES = 16,
  parameter int DOOR_CYCLES   = 32
) (
  input  logic                     clock,
  input  logic                     an_reset,
  input  logic [BUTTONS_WIDTH-1:0] active_in_levels,
  input  logic [BUTTONS_WIDTH-2:0] active_out_up_levels,
  input  logic [BUTTONS_WIDTH-1:1] active_out_down_levels,
  input  logic                     emergency_stop,
  output logic [BUTTONS_WIDTH-1:0] inactivate_in_levels,
  output logic [BUTTONS_WIDTH-2:0] inactivate_out_up_levels,
  output logic [BUTTONS_WIDTH-1:1] inactivate_out_down_levels,
  output logic                     buttons_block,
  output logic [FLOOR_WIDTH-1:0]   current_floor,
  output logic                     dir_up,
  output logic                     motor_up,
  output logic                     motor_down,
  output logic                     door_open
);

  localparam int TMAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [BUTTONS_WIDTH-1:0] ONE = 1;

  state_t                   state;
  logic [TW-1:0]            timer;
  logic [FLOOR_WIDTH-1:0]   nxt_floor;
  logic [BUTTONS_WIDTH-1:0] up_full, down_full;
  logic cur_up_here, cur_down_here, cur_above, cur_below, cur_stop_up, cur_stop_down;
  logic nxt_up_here, nxt_down_here, nxt_above, nxt_below, nxt_stop_up, nxt_stop_down;
  logic cur_req_here, cur_dir_door, nxt_dir_door, cur_inact_dir, seg_stop, seg_beyond;
  logic [BUTTONS_WIDTH-1:0] cur_hot, nxt_hot;
  logic [BUTTONS_WIDTH-2:0] cur_up_clr, nxt_up_clr;
  logic [BUTTONS_WIDTH-1:1] cur_dn_clr, nxt_dn_clr;

  assign up_full   = {1'b0, active_out_up_levels};
  assign down_full = {active_out_down_levels, 1'b0};

  // Floor the car reaches when the running segment completes; saturates at the ends.
  always_comb begin
    nxt_floor = current_floor;
    if (state == ST_MOVE_DOWN) begin
      if (current_floor != '0) nxt_floor = current_floor - 1'b1;
    end else if (current_floor != FLOOR_WIDTH'(BUTTONS_WIDTH - 1)) begin
      nxt_floor = current_floor + 1'b1;
    end
  end

  elevator_req_scan #(.BUTTONS_WIDTH(BUTTONS_WIDTH), .FLOOR_WIDTH(FLOOR_WIDTH)) u_cur_scan (
    .floor(current_floor), .in_levels(active_in_levels), .up_levels(up_full),
    .down_levels(down_full), .up_here(cur_up_here), .down_here(cur_down_here),
    .above(cur_above), .below(cur_below), .stop_up(cur_stop_up), .stop_down(cur_stop_down)
  );

  elevator_req_scan #(.BUTTONS_WIDTH(BUTTONS_WIDTH), .FLOOR_WIDTH(FLOOR_WIDTH)) u_nxt_scan (
    .floor(nxt_floor), .in_levels(active_in_levels), .up_levels(up_full),
    .down_levels(down_full), .up_here(nxt_up_here), .down_here(nxt_down_here),
    .above(nxt_above), .below(nxt_below), .stop_up(nxt_stop_up), .stop_down(nxt_stop_down)
  );

  // Either stop condition holding means some request sits at this floor.
  assign cur_req_here = cur_stop_up | cur_stop_down;
  assign cur_dir_door = door_dir(dir_up, cur_above, cur_below,
                                 dir_up ? cur_down_here : cur_up_here,
                                 at_top(int'(current_floor), BUTTONS_WIDTH),
                                 at_bottom(int'(current_floor)));
  assign nxt_dir_door = door_dir(dir_up, nxt_above, nxt_below,
                                 dir_up ? nxt_down_here : nxt_up_here,
                                 at_top(int'(nxt_floor), BUTTONS_WIDTH),
                                 at_bottom(int'(nxt_floor)));
  assign cur_inact_dir = (state == ST_DOOR_OPEN) ? dir_up : cur_dir_door;

  assign cur_hot    = ONE << current_floor;
  assign nxt_hot    = ONE << nxt_floor;
  assign cur_up_clr = cur_hot[BUTTONS_WIDTH-2:0] & {(BUTTONS_WIDTH-1){cur_inact_dir | ~cur_below}};
  assign cur_dn_clr = cur_hot[BUTTONS_WIDTH-1:1] & {(BUTTONS_WIDTH-1){~cur_inact_dir | ~cur_above}};
  assign nxt_up_clr = nxt_hot[BUTTONS_WIDTH-2:0] & {(BUTTONS_WIDTH-1){nxt_dir_door | ~nxt_below}};
  assign nxt_dn_clr = nxt_hot[BUTTONS_WIDTH-1:1] & {(BUTTONS_WIDTH-1){~nxt_dir_door | ~nxt_above}};

  assign seg_stop   = (state == ST_MOVE_UP) ? nxt_stop_up : nxt_stop_down;
  assign seg_beyond = (state == ST_MOVE_UP) ? nxt_above : nxt_below;

  always_ff @(posedge clock or negedge an_reset) begin
    if (!an_reset) begin
      state                      <= ST_IDLE;
      timer                      <= '0;
      current_floor              <= '0;
      dir_up                     <= DIR_UP;
      motor_up                   <= 1'b0;
      motor_down                 <= 1'b0;
      door_open                  <= 1'b0;
      buttons_block              <= 1'b0;
      inactivate_in_levels       <= '0;
      inactivate_out_up_levels   <= '0;
      inactivate_out_down_levels <= '0;
    end else if (emergency_stop) begin
      state                      <= ST_HALT;
      timer                      <= '0;
      motor_up                   <= 1'b0;
      motor_down                 <= 1'b0;
      buttons_block              <= 1'b1;
      inactivate_in_levels       <= '0;
      inactivate_out_up_levels   <= '0;
      inactivate_out_down_levels <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          timer <= '0;
          if (cur_req_here) begin
            state                      <= ST_DOOR_OPEN;
            door_open                  <= 1'b1;
            dir_up                     <= cur_dir_door;
            inactivate_in_levels       <= cur_hot;
            inactivate_out_up_levels   <= cur_up_clr;
            inactivate_out_down_levels <= cur_dn_clr;
          end else if (cur_above && (dir_up || !cur_below)) begin
            state    <= ST_MOVE_UP;
            motor_up <= 1'b1;
            dir_up   <= DIR_UP;
          end else if (cur_below) begin
            state      <= ST_MOVE_DOWN;
            motor_down <= 1'b1;
            dir_up     <= DIR_DOWN;
          end
        end
        ST_MOVE_UP, ST_MOVE_DOWN: begin
          if (timer == TW'(TRAVEL_CYCLES - 1)) begin
            timer         <= '0;
            current_floor <= nxt_floor;
            if (seg_stop) begin
              state                      <= ST_DOOR_OPEN;
              motor_up                   <= 1'b0;
              motor_down                 <= 1'b0;
              door_open                  <= 1'b1;
              dir_up                     <= nxt_dir_door;
              inactivate_in_levels       <= nxt_hot;
              inactivate_out_up_levels   <= nxt_up_clr;
              inactivate_out_down_levels <= nxt_dn_clr;
            end else if (!seg_beyond) begin
              // Requests ahead were withdrawn: park rather than run off the shaft.
              state      <= ST_IDLE;
              motor_up   <= 1'b0;
              motor_down <= 1'b0;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_DOOR_OPEN: begin
          if (timer == TW'(DOOR_CYCLES - 1)) begin
            state                      <= ST_IDLE;
            timer                      <= '0;
            door_open                  <= 1'b0;
            inactivate_in_levels       <= '0;
            inactivate_out_up_levels   <= '0;
            inactivate_out_down_levels <= '0;
          end else begin
            timer                      <= timer + 1'b1;
            inactivate_in_levels       <= cur_hot;
            inactivate_out_up_levels   <= cur_up_clr;
            inactivate_out_down_levels <= cur_dn_clr;
          end
        end
        ST_HALT: begin
          state         <= ST_IDLE;
          buttons_block <= 1'b0;
          door_open     <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_elevator_ctrl.sv
// Directed bench for elevator_ctrl with a small button-register model upstream.
// Table of {pulse requests, estop, cycles, expected outputs} plus a hand-written reset-in-door sequence.
module tb_elevator_ctrl;

  logic       clock;
  logic       an_reset;
  logic       emergency_stop;
  logic [7:0] set_in, set_up, set_dn;
  logic [7:0] act_in, act_up, act_dn;
  logic [7:0] inactivate_in_levels;
  logic [6:0] inactivate_out_up_levels;
  logic [7:1] inactivate_out_down_levels;
  logic       buttons_block, dir_up, motor_up, motor_down, door_open;
  logic [2:0] current_floor;
  logic [31:0] obs;

  int checks   = 0;
  int failures = 0;

  elevator_ctrl #(
    .BUTTONS_WIDTH(8), .FLOOR_WIDTH(3), .TRAVEL_CYCLES(4), .DOOR_CYCLES(3)
  ) dut (
    .clock(clock),
    .an_reset(an_reset),
    .active_in_levels(act_in),
    .active_out_up_levels(act_up[6:0]),
    .active_out_down_levels(act_dn[7:1]),
    .emergency_stop(emergency_stop),
    .inactivate_in_levels(inactivate_in_levels),
    .inactivate_out_up_levels(inactivate_out_up_levels),
    .inactivate_out_down_levels(inactivate_out_down_levels),
    .buttons_block(buttons_block),
    .current_floor(current_floor),
    .dir_up(dir_up),
    .motor_up(motor_up),
    .motor_down(motor_down),
    .door_open(door_open)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Upstream request register: latch new presses, clear on inactivate.
  always @(posedge clock or negedge an_reset) begin
    if (!an_reset) begin
      act_in <= '0;
      act_up <= '0;
      act_dn <= '0;
    end else begin
      act_in <= (act_in | set_in) & ~inactivate_in_levels;
      act_up <= (act_up | set_up) & ~{1'b0, inactivate_out_up_levels} & 8'h7f;
      act_dn <= (act_dn | set_dn) & ~{inactivate_out_down_levels, 1'b0} & 8'hfe;
    end
  end

  assign obs = {current_floor, dir_up, motor_up, motor_down, door_open, buttons_block,
                inactivate_in_levels, 1'b0, inactivate_out_up_levels,
                inactivate_out_down_levels, 1'b0};

  function automatic logic [31:0] e(input logic [2:0] f, input logic d, input logic mu,
                                    input logic md, input logic dr, input logic bk,
                                    input logic [7:0] i, input logic [7:0] u, input logic [7:0] n);
    return {f, d, mu, md, dr, bk, i, u, n};
  endfunction

  typedef struct {
    bit          rst;
    logic [7:0]  si, su, sd;
    bit          es;
    int          cyc;
    logic [31:0] exp;
  } vec_t;

  function automatic vec_t mk(input bit rst, input logic [7:0] si, input logic [7:0] su,
                              input logic [7:0] sd, input bit es, input int cyc,
                              input logic [31:0] exp);
    vec_t r;
    r.rst = rst; r.si = si; r.su = su; r.sd = sd; r.es = es; r.cyc = cyc; r.exp = exp;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    an_reset       = 1'b0;
    emergency_stop = 1'b0;
    set_in = '0; set_up = '0; set_dn = '0;
    repeat (2) @(negedge clock);
    an_reset = 1'b1;
  endtask

  localparam int NV = 29;
  vec_t v[NV];

  initial begin
    an_reset       = 1'b0;
    emergency_stop = 1'b0;
    set_in = '0; set_up = '0; set_dn = '0;

    // car call at 3 from reset
    v[0]  = mk(1, 8'h08, 8'h00, 8'h00, 0, 1,  e(0,1,0,0,0,0,8'h00,8'h00,8'h00));
    v[1]  = mk(0, 8'h00, 8'h00, 8'h00, 0, 1,  e(0,1,1,0,0,0,8'h00,8'h00,8'h00));
    v[2]  = mk(0, 8'h00, 8'h00, 8'h00, 0, 4,  e(1,1,1,0,0,0,8'h00,8'h00,8'h00));
    v[3]  = mk(0, 8'h00, 8'h00, 8'h00, 0, 8,  e(3,1,0,0,1,0,8'h08,8'h08,8'h08));
    v[4]  = mk(0, 8'h00, 8'h00, 8'h00, 0, 2,  e(3,1,0,0,1,0,8'h08,8'h08,8'h08));
    v[5]  = mk(0, 8'h00, 8'h00, 8'h00, 0, 1,  e(3,1,0,0,0,0,8'h00,8'h00,8'h00));
    // up[2] and down[5] from floor 0
    v[6]  = mk(1, 8'h00, 8'h04, 8'h20, 0, 2,  e(0,1,1,0,0,0,8'h00,8'h00,8'h00));
    v[7]  = mk(0, 8'h00, 8'h00, 8'h00, 0, 8,  e(2,1,0,0,1,0,8'h04,8'h04,8'h00));
    v[8]  = mk(0, 8'h00, 8'h00, 8'h00, 0, 3,  e(2,1,0,0,0,0,8'h00,8'h00,8'h00));
    v[9]  = mk(0, 8'h00, 8'h00, 8'h00, 0, 1,  e(2,1,1,0,0,0,8'h00,8'h00,8'h00));
    v[10] = mk(0, 8'h00, 8'h00, 8'h00, 0, 12, e(5,0,0,0,1,0,8'h20,8'h20,8'h20));
    v[11] = mk(0, 8'h00, 8'h00, 8'h00, 0, 3,  e(5,0,0,0,0,0,8'h00,8'h00,8'h00));
    // park at 4, then down[6] + in[7]: pass 6, serve 7, reverse, serve 6
    v[12] = mk(1, 8'h10, 8'h00, 8'h00, 0, 18, e(4,1,0,0,1,0,8'h10,8'h10,8'h10));
    v[13] = mk(0, 8'h00, 8'h00, 8'h00, 0, 3,  e(4,1,0,0,0,0,8'h00,8'h00,8'h00));
    v[14] = mk(0, 8'h80, 8'h00, 8'h40, 0, 2,  e(4,1,1,0,0,0,8'h00,8'h00,8'h00));
    v[15] = mk(0, 8'h00, 8'h00, 8'h00, 0, 8,  e(6,1,1,0,0,0,8'h00,8'h00,8'h00));
    v[16] = mk(0, 8'h00, 8'h00, 8'h00, 0, 4,  e(7,0,0,0,1,0,8'h80,8'h00,8'h80));
    v[17] = mk(0, 8'h00, 8'h00, 8'h00, 0, 4,  e(7,0,0,1,0,0,8'h00,8'h00,8'h00));
    v[18] = mk(0, 8'h00, 8'h00, 8'h00, 0, 4,  e(6,0,0,0,1,0,8'h40,8'h40,8'h40));
    // emergency stop mid-segment 1->2, release, full segment
    v[19] = mk(1, 8'h04, 8'h00, 8'h00, 0, 7,  e(1,1,1,0,0,0,8'h00,8'h00,8'h00));
    v[20] = mk(0, 8'h00, 8'h00, 8'h00, 1, 1,  e(1,1,0,0,0,1,8'h00,8'h00,8'h00));
    v[21] = mk(0, 8'h00, 8'h00, 8'h00, 1, 5,  e(1,1,0,0,0,1,8'h00,8'h00,8'h00));
    v[22] = mk(0, 8'h00, 8'h00, 8'h00, 0, 1,  e(1,1,0,0,0,0,8'h00,8'h00,8'h00));
    v[23] = mk(0, 8'h00, 8'h00, 8'h00, 0, 1,  e(1,1,1,0,0,0,8'h00,8'h00,8'h00));
    v[24] = mk(0, 8'h00, 8'h00, 8'h00, 0, 3,  e(1,1,1,0,0,0,8'h00,8'h00,8'h00));
    v[25] = mk(0, 8'h00, 8'h00, 8'h00, 0, 1,  e(2,1,0,0,1,0,8'h04,8'h04,8'h04));
    // hall down at the idle floor: door next cycle, no motion
    v[26] = mk(0, 8'h00, 8'h00, 8'h00, 0, 3,  e(2,1,0,0,0,0,8'h00,8'h00,8'h00));
    v[27] = mk(0, 8'h00, 8'h00, 8'h04, 0, 2,  e(2,0,0,0,1,0,8'h04,8'h04,8'h04));
    // travel to 5 for the reset-in-door sequence
    v[28] = mk(1, 8'h20, 8'h00, 8'h00, 0, 22, e(5,1,0,0,1,0,8'h20,8'h20,8'h20));

    for (int k = 0; k < NV; k++) begin
      if (v[k].rst) begin
        do_reset();
        chk($sformatf("reset_before_vec%0d", k), e(0,1,0,0,0,0,8'h00,8'h00,8'h00));
      end
      set_in = v[k].si; set_up = v[k].su; set_dn = v[k].sd;
      emergency_stop = v[k].es;
      @(negedge clock);
      set_in = '0; set_up = '0; set_dn = '0;
      repeat (v[k].cyc - 1) @(negedge clock);
      chk($sformatf("vec%0d", k), v[k].exp);
    end

    // asynchronous reset while the door is open at floor 5
    #2 an_reset = 1'b0;
    #1 chk("async_reset_in_door", e(0,1,0,0,0,0,8'h00,8'h00,8'h00));
    @(negedge clock);
    an_reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("idle_after_reset", e(0,1,0,0,0,0,8'h00,8'h00,8'h00));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
